prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Parametrised, boot-loadable instruction memory that replaces the fixed test ROM in front of the CPU fetch path.
- A byte-wide loader stream (e.g. from a UART bridge) assembles DATA_WIDTH-bit instructions and writes them to internal RAM.
- The CPU then fetches with a one-cycle registered read.
- Unloaded or out-of-range addresses return NOP (all zeros), so x/z never reaches decode.

Parameters:
DATA_WIDTH, 38, instruction word width (opcode[4] s[2] a[16] b[16])
ADDR_WIDTH, 12, fetch address width
DEPTH, 4096, number of words; must be <= 2**ADDR_WIDTH
BYTE_WIDTH, 8, loader stream width; BPW = ceil(DATA_WIDTH/BYTE_WIDTH) bytes per word (5 at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load_start  in  1  one-cycle pulse: enter LOAD, clear count
ld_valid  in  1  loader byte valid
ld_data  in  BYTE_WIDTH  loader byte
ld_last  in  1  qualifies final byte of image, with ld_valid
ld_ready  out  1  byte accepted when ld_valid && ld_ready
ld_done  out  1  one-cycle pulse when load completes
ld_overflow  out  1  sticky: image exceeded DEPTH
word_count  out  ADDR_WIDTH+1  number of words loaded
fetch_req  in  1  fetch strobe
fetch_addr  in  ADDR_WIDTH  word address
instruction  out  DATA_WIDTH  fetched word, registered
instr_valid  out  1  high the cycle after an accepted fetch_req

Behaviour:
- Clock/reset: single clock `clk`. Reset is synchronous, active-low, on `rst_n`.
- Reset values:
  - state = IDLE.
  - ld_ready, ld_done, ld_overflow, instr_valid = 0.
  - word_count = 0, instruction = 0.
  - Byte index and assembly register cleared.
  - RAM contents are not cleared; they are masked by word_count.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - LOAD -> RUN after accepting the byte with ld_last=1.
  - RUN -> LOAD on load_start.
  - load_start in LOAD restarts the load: count, byte index and ld_overflow are cleared. Any byte presented in that same cycle is dropped.
- LOAD:
  - ld_ready = 1 from the cycle after load_start.
  - Bytes are packed little-endian: byte k of a word lands at bits [k*BYTE_WIDTH +: BYTE_WIDTH]. Bits of the final byte above DATA_WIDTH-1 are discarded.
  - On the BPW-th byte, the word is written at address word_count, and word_count increments on the same clock edge.
  - ld_last mid-word: remaining bytes are zero-padded and the partial word is written and counted.
  - When word_count == DEPTH, further completed words are discarded, word_count holds, and ld_overflow is set. ld_overflow stays set until the next load_start or reset.
  - On the ld_last byte: ld_ready drops the next cycle, ld_done pulses for one cycle, and state becomes RUN.
- Fetch:
  - A fetch_req accepted in RUN gives instr_valid=1 and instruction = RAM[fetch_addr] on the next cycle (latency 1).
  - If fetch_addr >= word_count, instruction = 0 (NOP).
  - fetch_req every cycle is allowed; throughput is 1 word per cycle.
  - With no fetch_req, instr_valid = 0 and instruction holds its last value.
  - fetch_req in IDLE or LOAD is ignored: instr_valid = 0 and instruction = 0.
- Reset mid-load: returns to IDLE with word_count = 0. A partially assembled word is lost.

Test Plan:
- Basic load and fetch: load_start, then bytes 02 00 00 10 04 (ld_last on the 5th) -> ld_done pulses, word_count=1. Fetch addr 0 -> next cycle instruction = 38'h04_1000_0002 (mov r1,#2), instr_valid=1.
- Back-to-back fetch: load 3 words, then fetch_req on addr 0,1,2 in consecutive cycles -> three consecutive instr_valid cycles with the matching words. Fetch addr 3 -> instruction=0.
- Partial word: bytes 0B 00 (ld_last on the 2nd) -> word_count=1, word 0 = 38'h00_0000_000B.
- Overflow: with DEPTH=4, stream 6 words -> word_count=4, ld_overflow=1, words 0-3 intact. The next load_start clears ld_overflow.
- Reset mid-load: rst_n=0 after 7 bytes -> state IDLE, word_count=0, ld_ready=0. fetch_req gives instr_valid=0.
- Reload from RUN: load_start in RUN, load 1 word -> word_count=1. The old address 2 now reads 0.

Source files
------------

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
//
// Boot-loadable instruction memory that sits in front of the CPU fetch path.
// A byte-wide loader stream assembles DATA_WIDTH-bit words little-endian and
// writes them to an internal RAM. Once the image is complete the CPU fetches
// with one cycle of latency. Addresses at or above word_count read as NOP
// (all zeros), so stale or uninitialised RAM contents never reach decode.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   load_start      one-cycle pulse: (re)start a load, clear count/overflow
//   ld_valid        loader byte valid
//   ld_data         loader byte
//   ld_last         marks the final byte of the image (with ld_valid)
//   ld_ready        byte accepted when ld_valid && ld_ready
//   ld_done         one-cycle pulse when the final byte is accepted
//   ld_overflow     sticky: image held more than DEPTH words
//   word_count      number of words stored by the current/last load
//   fetch_req       fetch strobe (honoured only in RUN)
//   fetch_addr      word address to fetch
//   instruction     fetched word, registered
//   instr_valid     high the cycle after an accepted fetch_req
// ---------------------------------------------------------------------------
module prog_mem_loader #(
    parameter int DATA_WIDTH = 38,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  ld_valid,
    input  logic [BYTE_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_overflow,
    output logic [ADDR_WIDTH:0]   word_count,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid
);

    localparam int BPW   = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int ASM_W = BPW * BYTE_WIDTH;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic                   ld_ready_q, ld_ready_d;
    logic                   ld_done_q, ld_done_d;
    logic                   ld_overflow_q, ld_overflow_d;
    logic [ADDR_WIDTH:0]    word_count_q, word_count_d;
    logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [ASM_W-1:0]       asm_q, asm_d;
    logic [DATA_WIDTH-1:0]  instruction_q, instruction_d;
    logic                   instr_valid_q, instr_valid_d;

    logic                   byte_accept;
    logic                   word_done;
    logic [ASM_W-1:0]       asm_next;
    logic                   ram_we;
    logic [ADDR_WIDTH-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0]  ram_wdata;

    logic [DATA_WIDTH-1:0]  ram [DEPTH];

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the branches can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        ld_ready_d    = ld_ready_q;
        ld_done_d     = 1'b0;
        ld_overflow_d = ld_overflow_q;
        word_count_d  = word_count_q;
        byte_idx_d    = byte_idx_q;
        asm_d         = asm_q;
        instruction_d = instruction_q;
        instr_valid_d = 1'b0;

        // A byte arriving together with load_start belongs to the aborted
        // image and is dropped.
        byte_accept = (state_q == LOAD) && ld_ready_q && ld_valid && !load_start;

        asm_next = asm_q;
        asm_next[byte_idx_q*BYTE_WIDTH +: BYTE_WIDTH] = ld_data;

        // ld_last closes a partial word; the unfilled bytes are still zero
        // because the assembly register is cleared after every word.
        word_done = byte_accept && (ld_last || (byte_idx_q == LAST_IDX));
        ram_we    = word_done && (word_count_q != DEPTH_CNT);
        ram_waddr = word_count_q[ADDR_WIDTH-1:0];
        ram_wdata = asm_next[DATA_WIDTH-1:0];  // drops pad bits of the top byte

        if (load_start) begin
            state_d       = LOAD;
            ld_ready_d    = 1'b1;
            ld_overflow_d = 1'b0;
            word_count_d  = '0;
            byte_idx_d    = '0;
            asm_d         = '0;
        end else if (byte_accept) begin
            if (word_done) begin
                byte_idx_d = '0;
                asm_d      = '0;
                if (ram_we) begin
                    word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
                end else begin
                    ld_overflow_d = 1'b1;
                end
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                asm_d      = asm_next;
            end
            if (ld_last) begin
                state_d    = RUN;
                ld_ready_d = 1'b0;
                ld_done_d  = 1'b1;
            end
        end

        // Fetch path: only RUN serves words; a request elsewhere returns NOP.
        if (fetch_req) begin
            instr_valid_d = (state_q == RUN);
            if ((state_q == RUN) && ({1'b0, fetch_addr} < word_count_q)) begin
                instruction_d = ram[fetch_addr];
            end else begin
                instruction_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ld_ready_q    <= 1'b0;
            ld_done_q     <= 1'b0;
            ld_overflow_q <= 1'b0;
            word_count_q  <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_ready_q    <= ld_ready_d;
            ld_done_q     <= ld_done_d;
            ld_overflow_q <= ld_overflow_d;
            word_count_q  <= word_count_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // NOTE: the RAM array has no reset; contents beyond word_count are masked
    // on read, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign ld_done     = ld_done_q;
    assign ld_overflow = ld_overflow_q;
    assign word_count  = word_count_q;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loader
//
// Self-checking bench for prog_mem_loader, built with DEPTH=4 so overflow is
// reachable quickly. Expected fetch results are pushed to a scoreboard queue
// when fetch_req is driven and popped when instr_valid appears.
// ---------------------------------------------------------------------------
module tb_prog_mem_loader;

    localparam int DW    = 38;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int BW    = 8;
    localparam int BPW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [BW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_overflow;
    logic [AW:0]   word_count;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] instruction;
    logic          instr_valid;

    prog_mem_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .BYTE_WIDTH (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .ld_overflow (ld_overflow),
        .word_count  (word_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] model_mem [DEPTH];
    int            model_count = 0;
    bit            model_run   = 1'b0;
    logic [DW-1:0] last_instr  = '0;
    logic [DW-1:0] words [6];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (instr_valid) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("fetch_word", 64'(instruction), 64'(e));
            end
        end
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [BW-1:0] d, input bit last);
        int budget;
        budget   = 20;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (!ld_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("ld_ready_timeout", 64'(ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start  = 1'b0;
        model_run   = 1'b0;
        model_count = 0;
        check("start_ready", 64'(ld_ready), 64'd1);
        check("start_count", 64'(word_count), 64'd0);
        check("start_ovf", 64'(ld_overflow), 64'd0);
    endtask

    task automatic finish_load(input bit exp_ovf);
        model_run = 1'b1;
        check("done_pulse", 64'(ld_done), 64'd1);
        check("ready_drop", 64'(ld_ready), 64'd0);
        check("word_count", 64'(word_count), 64'(model_count));
        check("overflow", 64'(ld_overflow), 64'(exp_ovf));
        tick();
        check("done_one_cycle", 64'(ld_done), 64'd0);
    endtask

    task automatic load_words(input int n);
        logic [39:0] tmp;
        for (int i = 0; i < n; i++) begin
            tmp = {2'b00, words[i]};
            for (int k = 0; k < BPW; k++) begin
                send_byte(tmp[k*8 +: 8], (i == n - 1) && (k == BPW - 1));
            end
            if (i < DEPTH) model_mem[i] = words[i];
        end
        model_count = (n < DEPTH) ? n : DEPTH;
        finish_load(n > DEPTH);
    endtask

    task automatic fetch(input int addr);
        logic [DW-1:0] e;
        fetch_req  = 1'b1;
        fetch_addr = AW'(addr);
        e = '0;
        if (model_run && addr < model_count) e = model_mem[addr];
        if (model_run) sb.push_back(e);
        last_instr = e;
        tick();
    endtask

    task automatic fetch_end();
        fetch_req = 1'b0;
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("valid_low_idle", 64'(instr_valid), 64'd0);
        check("instr_hold", 64'(instruction), 64'(last_instr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        words[0] = 38'h11_2233_4455;
        words[1] = 38'h2A_BCDE_F012;
        words[2] = 38'h3F_FFFF_FFFF;
        words[3] = 38'h00_0000_0001;
        words[4] = 38'h15_5555_AAAA;
        words[5] = 38'h2C_0FF0_1234;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ready", 64'(ld_ready), 64'd0);
        check("rst_done", 64'(ld_done), 64'd0);
        check("rst_ovf", 64'(ld_overflow), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic load of one word and fetch
        start_load();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h04, 1'b1);
        model_mem[0] = 38'h04_1000_0002;
        model_count  = 1;
        finish_load(1'b0);
        fetch(0);
        fetch_end();

        // Three words, back-to-back fetch, then an unloaded address
        start_load();
        load_words(3);
        fetch(0);
        fetch(1);
        fetch(2);
        fetch(3);
        fetch_end();

        // Partial word reload from RUN; old addresses now read NOP
        start_load();
        send_byte(8'h0B, 1'b0);
        send_byte(8'h00, 1'b1);
        model_mem[0] = 38'h00_0000_000B;
        model_count  = 1;
        finish_load(1'b0);
        fetch(0);
        fetch(2);
        fetch(1);
        fetch_end();

        // Overflow: six words into a four-word memory
        start_load();
        load_words(6);
        fetch(0);
        fetch(1);
        fetch(2);
        fetch(3);
        fetch(4);
        fetch(100);
        fetch_end();

        // Next load_start clears overflow; fetch in LOAD is ignored
        start_load();
        fetch(0);
        fetch_end();

        // Reset after seven bytes of a new image
        for (int k = 0; k < 7; k++) send_byte(8'(8'h30 + k), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        model_run = 1'b0;
        check("midrst_count", 64'(word_count), 64'd0);
        check("midrst_ready", 64'(ld_ready), 64'd0);
        check("midrst_ovf", 64'(ld_overflow), 64'd0);
        check("midrst_instr", 64'(instruction), 64'd0);
        fetch(0);
        fetch_end();

        // load_start inside LOAD restarts; the coincident byte is dropped and
        // the top byte's bits above DATA_WIDTH are discarded
        start_load();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        load_start = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 8'hEE;
        tick();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        check("restart_count", 64'(word_count), 64'd0);
        check("restart_ready", 64'(ld_ready), 64'd1);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hC3, 1'b1);
        model_mem[0] = 38'h03_1234_5678;
        model_count  = 1;
        finish_load(1'b0);
        fetch(0);
        fetch(1);
        fetch_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
